key_debounce: RTL and testbench
===============================

# key_debounce

Conditions a raw mechanical key or switch input into a clean, single-clock-domain level that drives the `d` input of the downstream `dff1` stage. A two-flop synchronizer removes metastability, then a counter-qualified state machine accepts a new level only after it has been stable for a programmable number of clocks. Optional one-cycle edge pulses report accepted transitions to later logic.

## Interface

- `DEBOUNCE_CYCLES`, default 240000: consecutive stable clocks required to accept a new level (20 ms at 12 MHz); legal range 1 .. 2^CNT_W.
- `CNT_W`, default 18: width of the stability counter.
- `INIT_LEVEL`, default 1'b1: idle level of the key (pull-up, active-low keys).
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  reset, synchronous and active-high; one clock, one reset.
- `key_raw`  input  1  asynchronous raw key/switch level.
- `d`  output  1  debounced level, feeds `dff1.d`.
- `rise`  output  1  one-cycle pulse when `d` goes 0→1.
- `fall`  output  1  one-cycle pulse when `d` goes 1→0.

## Operation

- Synchronizer: `s1 <= key_raw; s2 <= s1`; both reset to INIT_LEVEL.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. Reset state is STABLE_HI if INIT_LEVEL=1, else STABLE_LO.
- STABLE_x: `cnt` held at 0. If `s2` differs from the current level, go to WAIT of the opposite level, with `cnt` = 0.
- WAIT_x, with `s2` equal to the candidate level:
  - if `cnt == DEBOUNCE_CYCLES-1`: go to STABLE of the candidate level, update `d`, pulse `rise` or `fall`, clear `cnt`;
  - else `cnt <= cnt + 1`.
- WAIT_x, with `s2` back at the old level: return to the old STABLE state, clear `cnt`, leave `d` unchanged, no pulse (glitch rejected).
- `d` is a register, written only on an accepted transition. It equals the level of the current STABLE state, or of the state the WAIT began from.
- `cnt` never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Reset mid-WAIT: the pending transition is abandoned. `d` returns to INIT_LEVEL, and `cnt`, `rise` and `fall` go to 0.
- Reset values: `d` = INIT_LEVEL, `rise` = 0, `fall` = 0, `cnt` = 0, `s1` = `s2` = INIT_LEVEL.

## Timing

- `key_raw` sampled at edge N and held afterwards:
  - `s2` changes at N+1;
  - FSM enters WAIT at N+2;
  - `d` changes at edge N+DEBOUNCE_CYCLES+2.
- `rise`/`fall` assert in the same cycle that `d` changes and last exactly one cycle. They never assert together.
- Any mismatch in WAIT restarts qualification: the full DEBOUNCE_CYCLES are counted again after the next change.
- Minimum accepted pulse width on `key_raw`: DEBOUNCE_CYCLES+1 clocks.
- No combinational path from `key_raw` to any output.

## Configuration

- `KEY_DEBOUNCE_EDGE_EN` defined: `rise`/`fall` logic is compiled in as described.
- Not defined: `rise` and `fall` are tied to 0 and their registers are removed. `d` and its timing are unchanged.

## Structure

- Package `key_debounce_pkg` holds:
  - the state typedef (2-bit encoding STABLE_LO=0, WAIT_HI=1, STABLE_HI=2, WAIT_LO=3);
  - the default-cycle constant.
- Sub-module `sync_2ff`: the parameterized two-flop synchronizer with reset value INIT_LEVEL. It is reusable for other board inputs.
- FSM, counter and edge pulses stay in the top module.

## Test plan

Bench uses DEBOUNCE_CYCLES=4, CNT_W=3, INIT_LEVEL=1, 20 ns clock.

- Reset with `key_raw`=0: for the whole time `rst`=1, required `d`=1, `rise`=`fall`=0. After release, `d` falls at edge 6 (release = edge 0 sample).
- `key_raw` 1→0 at sample edge N, held: `d`=0 at N+6, `fall`=1 for exactly that one cycle, `rise`=0 throughout.
- `key_raw` 0 pulse lasting 3 clocks, then back to 1: `d` stays 1 and no pulse on `fall`.
- Bounce train 0,1,0,1,0 (1 clock each), then held 0: `d` falls exactly 6 clocks after the final 0 is sampled.
- `rst` asserted while in WAIT_LO with `cnt`=2: the next cycle shows `d`=1 and `cnt`=0. With `key_raw` still 0, `d` falls 6 clocks after `rst` drops.
- Build without `KEY_DEBOUNCE_EDGE_EN`: repeat scenario 2; `d` timing is identical and `rise`=`fall`=0 throughout.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the key debouncer.
package key_debounce_pkg;

  // Debounce FSM states; the encoding is fixed so it stays readable in waveforms.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } kd_state_e;

  // 20 ms of stability at a 12 MHz system clock.
  localparam int KD_DEFAULT_CYCLES = 240000;

  // Stable state that corresponds to a given idle level.
  function automatic kd_state_e kd_stable_state(input logic level);
    return level ? STABLE_HI : STABLE_LO;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs, reset to a known level.
module sync_2ff #(
  parameter int                WIDTH      = 1,
  parameter logic [WIDTH-1:0]  INIT_LEVEL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;

  // Shift the raw level through two stages.
  always_comb begin
    s1_d = din;
    s2_d = s1_q;
  end

  // Synchronizer flops, forced to the idle level during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= INIT_LEVEL;
      s2_q <= INIT_LEVEL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign dout = s2_q;

endmodule

// File: rtl/key_debounce.sv
// Key/switch debouncer: 2-FF synchronizer, counter-qualified FSM, optional
// rise/fall pulses. Define KEY_DEBOUNCE_EDGE_EN to build the edge pulses;
// otherwise rise and fall are constant 0.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = KD_DEFAULT_CYCLES,
  parameter int   CNT_W           = 18,
  parameter logic INIT_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic d,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam kd_state_e        RESET_STATE = kd_stable_state(INIT_LEVEL);

  logic             key_s;
  kd_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_q, d_d;

  sync_2ff #(
    .WIDTH      (1),
    .INIT_LEVEL (INIT_LEVEL)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (key_raw),
    .dout (key_s)
  );

  // Next state: accept a new level only after CNT_MAX+1 consecutive matching samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    unique case (state_q)
      STABLE_LO: begin
        cnt_d = '0;
        if (key_s) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (key_s) begin
          if (cnt_q == CNT_MAX) begin
            state_d = STABLE_HI;
            d_d     = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      end
      STABLE_HI: begin
        cnt_d = '0;
        if (!key_s) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!key_s) begin
          if (cnt_q == CNT_MAX) begin
            state_d = STABLE_LO;
            d_d     = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and debounced level registers; reset abandons any pending change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      d_q     <= INIT_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
    end
  end

  assign d = d_q;

`ifdef KEY_DEBOUNCE_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // An accepted transition is exactly a change of the debounced level.
  always_comb begin
    rise_d = d_d & ~d_q;
    fall_d = ~d_d & d_q;
  end

  // Registered pulses line up with the cycle in which d changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, CNT_W=3, INIT_LEVEL=1.
module tb_key_debounce;
  import key_debounce_pkg::*;

  localparam int DC = 4;
`ifdef KEY_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic key_raw;
  logic d, rise, fall;

  int checks = 0;
  int errors = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (3),
    .INIT_LEVEL      (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_raw (key_raw),
    .d       (d),
    .rise    (rise),
    .fall    (fall)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // d, rise and fall all at their quiet values for a given held level.
  task automatic check_quiet(input string tag, input logic level);
    check({tag, "_d"}, {31'd0, d}, {31'd0, level});
    check({tag, "_rise"}, {31'd0, rise}, 32'd0);
    check({tag, "_fall"}, {31'd0, fall}, 32'd0);
  endtask

  // key_raw is already at new_level; the first step is sample edge 0 and
  // d must change exactly at edge n with a one-cycle pulse (when built in).
  task automatic expect_edge(input int n, input logic new_level, input string tag);
    logic exp_d, exp_r, exp_f;
    for (int i = 0; i <= n + 1; i++) begin
      step();
      exp_d = (i < n) ? ~new_level : new_level;
      exp_r = EDGE_EN && new_level && (i == n);
      exp_f = EDGE_EN && !new_level && (i == n);
      check({tag, "_d"}, {31'd0, d}, {31'd0, exp_d});
      check({tag, "_rise"}, {31'd0, rise}, {31'd0, exp_r});
      check({tag, "_fall"}, {31'd0, fall}, {31'd0, exp_f});
    end
  endtask

  initial begin
    // Reset held with the key pressed: outputs stay at the idle level.
    rst     = 1'b1;
    key_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet("in_reset", 1'b1);
    end
    rst = 1'b0;
    expect_edge(DC + 2, 1'b0, "rst_release");

    // Release the key and return to the idle level.
    key_raw = 1'b1;
    expect_edge(DC + 2, 1'b1, "release1");

    // Clean press held.
    key_raw = 1'b0;
    expect_edge(DC + 2, 1'b0, "press");
    key_raw = 1'b1;
    expect_edge(DC + 2, 1'b1, "release2");

    // Three-clock glitch low is rejected.
    key_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet("glitch_lo", 1'b1);
    end
    key_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_quiet("glitch_after", 1'b1);
    end

    // Bounce train 0,1,0,1 then the final 0 held.
    key_raw = 1'b0; step(); check_quiet("bounce0", 1'b1);
    key_raw = 1'b1; step(); check_quiet("bounce1", 1'b1);
    key_raw = 1'b0; step(); check_quiet("bounce2", 1'b1);
    key_raw = 1'b1; step(); check_quiet("bounce3", 1'b1);
    key_raw = 1'b0;
    expect_edge(DC + 2, 1'b0, "bounce_final");
    key_raw = 1'b1;
    expect_edge(DC + 2, 1'b1, "release3");

    // Reset in WAIT_LO with cnt=2 abandons the pending fall.
    key_raw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_quiet("pre_rst", 1'b1);
    end
    check("wait_state", {30'd0, dut.state_q}, {30'd0, WAIT_LO});
    check("wait_cnt", {29'd0, dut.cnt_q}, 32'd2);
    rst = 1'b1;
    step();
    check_quiet("mid_rst", 1'b1);
    check("mid_rst_cnt", {29'd0, dut.cnt_q}, 32'd0);
    check("mid_rst_state", {30'd0, dut.state_q}, {30'd0, STABLE_HI});
    rst = 1'b0;
    expect_edge(DC + 2, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
